// File: rtl/des_key_pkg.sv
// DES key-schedule tables (PC-1, PC-2, rotation schedule), shared types and helpers.
// Latency: none; constants and combinational functions only.
// Backpressure: not applicable.
package des_key_pkg;

  typedef logic [1:28] half_t;
  typedef logic [1:56] cd_t;
  typedef logic [1:48] subkey_t;

  typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

  // Entry i names the key bit (1 = MSB) that becomes bit i of {C,D}.
  localparam int PC1 [1:56] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  // Entry i names the {C,D} bit that becomes subkey bit i.
  localparam int PC2 [1:48] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  // Left-rotate amount applied to reach round i from round i-1.
  localparam int SHIFT [1:16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  // PC-1 drops the eight parity bits, so they never influence the schedule.
  function automatic cd_t pc1(input logic [1:64] k);
    cd_t cd;
    cd = '0;
    for (int i = 1; i <= 56; i++) begin
      cd[i] = k[PC1[i]];
    end
    return cd;
  endfunction

  // Rotate toward bit 1 (the MSB) by one or two places.
  function automatic half_t rotl(input half_t h, input logic two);
    return two ? {h[3:28], h[1:2]} : {h[2:28], h[1]};
  endfunction

  // Rotate toward bit 28 (the LSB) by one or two places.
  function automatic half_t rotr(input half_t h, input logic two);
    return two ? {h[27:28], h[1:26]} : {h[28], h[1:27]};
  endfunction

endpackage

// File: rtl/des_pc2.sv
// DES Permuted Choice 2: selects 48 of the 56 C/D bits to form a round subkey.
// Latency: purely combinational.
// Backpressure: not applicable.
module des_pc2
  import des_key_pkg::*;
(
  input  logic [1:56] i_cd,
  output logic [1:48] o_subkey
);

  // Fixed bit gather through the PC-2 table.
  always_comb begin
    o_subkey = '0;
    for (int i = 1; i <= 48; i++) begin
      o_subkey[i] = i_cd[PC2[i]];
    end
  end

endmodule

// File: rtl/des_subkey_sequencer.sv
// Sequential DES key schedule: emits K1..K16 (or K16..K1) one per valid/ready handshake.
// Latency: first subkey valid the cycle after start is accepted; one subkey per cycle when ready.
// Backpressure: subkey/round/last hold while ready is low; start ignored while busy.
module des_subkey_sequencer
  import des_key_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic        i_decrypt,
  input  logic [1:64] i_key,
  output logic        o_busy,
  output logic        o_subkey_valid,
  input  logic        i_subkey_ready,
  output logic [1:48] o_subkey,
  output logic [4:0]  o_round,
  output logic        o_last
);

  state_t      r_state;
  state_t      w_state_nxt;
  half_t       r_c;
  half_t       r_d;
  logic [3:0]  r_count;
  logic        r_dec;

  logic        w_run;
  logic        w_load;
  logic        w_fire;
  logic        w_step;
  logic        w_final;
  cd_t         w_pc1;
  logic [4:0]  w_shift_idx;
  logic        w_two;

  assign w_run   = (r_state == ST_RUN);
  assign w_load  = (r_state == ST_IDLE) && i_start;
  assign w_fire  = w_run && i_subkey_ready;
  assign w_final = (r_count == 4'd15);
  assign w_step  = w_fire && !w_final;
  assign w_pc1   = pc1(i_key);

  // Encrypt moves to round count+2 using that round's shift; decrypt undoes the
  // shift of the round currently presented (16-count).
  assign w_shift_idx = r_dec ? (5'd16 - {1'b0, r_count}) : ({1'b0, r_count} + 5'd2);
  assign w_two       = (SHIFT[w_shift_idx] == 2);

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: leave RUN only on the handshake of the 16th subkey.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (i_start) w_state_nxt = ST_RUN;
      ST_RUN:  if (w_fire && w_final) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Output decode; round is derived from count and the latched direction.
  always_comb begin
    o_busy         = w_run;
    o_subkey_valid = w_run;
    o_last         = w_run && w_final;
    o_round        = 5'd0;
    if (w_run) begin
      o_round = r_dec ? (5'd16 - {1'b0, r_count}) : ({1'b0, r_count} + 5'd1);
    end
  end

  // C/D halves, handshake counter and direction flag. Decrypt loads C0/D0 directly
  // because the full schedule rotates by 28, which makes them equal to C16/D16.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_c     <= '0;
      r_d     <= '0;
      r_count <= 4'd0;
      r_dec   <= 1'b0;
    end else if (w_load) begin
      r_dec   <= i_decrypt;
      r_count <= 4'd0;
      if (i_decrypt) begin
        r_c <= w_pc1[1:28];
        r_d <= w_pc1[29:56];
      end else begin
        r_c <= rotl(w_pc1[1:28], 1'b0);
        r_d <= rotl(w_pc1[29:56], 1'b0);
      end
    end else if (w_step) begin
      r_count <= r_count + 4'd1;
      if (r_dec) begin
        r_c <= rotr(r_c, w_two);
        r_d <= rotr(r_d, w_two);
      end else begin
        r_c <= rotl(r_c, w_two);
        r_d <= rotl(r_d, w_two);
      end
    end
  end

  des_pc2 u_pc2 (
    .i_cd     ({r_c, r_d}),
    .o_subkey (o_subkey)
  );

endmodule

// File: tb/tb_des_subkey_sequencer.sv
// Directed bench for des_subkey_sequencer with a subkey scoreboard.
// Latency: n/a.
// Backpressure: drives random or constant ready.
module tb_des_subkey_sequencer;

  typedef struct {
    logic [47:0] sk;
    logic [4:0]  rnd;
    logic        last;
  } exp_t;

  // Published subkeys for key 133457799BBCDFF1.
  localparam logic [47:0] GOLD [1:16] = '{
    48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
    48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
    48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
    48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
  };
  localparam logic [63:0] KEY     = 64'h133457799BBCDFF1;
  localparam logic [63:0] PAR_MSK = 64'h0101010101010101;
  localparam int          CYC_MAX = 200;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_start;
  logic        i_decrypt;
  logic [1:64] i_key;
  logic        o_busy;
  logic        o_subkey_valid;
  logic        i_subkey_ready;
  logic [1:48] o_subkey;
  logic [4:0]  o_round;
  logic        o_last;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb[$];

  des_subkey_sequencer dut (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_start        (i_start),
    .i_decrypt      (i_decrypt),
    .i_key          (i_key),
    .o_busy         (o_busy),
    .o_subkey_valid (o_subkey_valid),
    .i_subkey_ready (i_subkey_ready),
    .o_subkey       (o_subkey),
    .o_round        (o_round),
    .o_last         (o_last)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One full request. stray_at: handshake index at which a foreign start is pulsed;
  // rst_at: handshake index at which reset is asserted; start_at_last: pulse start
  // on the cycle the final handshake completes.
  task automatic run_seq(input logic [63:0] key, input logic dec, input bit rnd_rdy,
                         input int stray_at, input int rst_at, input bit start_at_last);
    exp_t        e;
    int          hs;
    int          cyc;
    bit          hold;
    bit          aborted;
    bit          rdy;
    logic [47:0] h_sk;
    logic [4:0]  h_rnd;
    logic        h_last;
    hs = 0; cyc = 0; hold = 0; aborted = 0;
    h_sk = '0; h_rnd = '0; h_last = 1'b0;
    @(negedge i_clk);
    check("idle_busy", {63'd0, o_busy}, 64'd0);
    i_key     = key;
    i_decrypt = dec;
    i_start   = 1'b1;
    for (int i = 0; i < 16; i++) begin
      e.rnd  = dec ? 5'(16 - i) : 5'(i + 1);
      e.sk   = GOLD[int'(e.rnd)];
      e.last = (i == 15);
      sb.push_back(e);
    end
    @(negedge i_clk);
    i_start = 1'b0;
    check("first_valid", {63'd0, o_subkey_valid}, 64'd1);
    while (hs < 16 && cyc < CYC_MAX && !aborted) begin
      if (hold) begin
        check("hold_subkey", {16'd0, o_subkey}, {16'd0, h_sk});
        check("hold_round", {59'd0, o_round}, {59'd0, h_rnd});
        check("hold_last", {63'd0, o_last}, {63'd0, h_last});
      end
      if (hs == rst_at) begin
        i_subkey_ready = 1'b0;
        i_rst_n = 1'b0;
        #1;
        check("rst_valid", {63'd0, o_subkey_valid}, 64'd0);
        check("rst_busy", {63'd0, o_busy}, 64'd0);
        check("rst_subkey", {16'd0, o_subkey}, 64'd0);
        check("rst_round", {59'd0, o_round}, 64'd0);
        sb.delete();
        @(negedge i_clk);
        i_rst_n = 1'b1;
        aborted = 1;
      end else begin
        check("run_valid", {63'd0, o_subkey_valid}, 64'd1);
        if (o_subkey_valid !== 1'b1) aborted = 1;
        rdy = rnd_rdy ? ($urandom_range(0, 1) == 1) : 1'b1;
        i_subkey_ready = rdy;
        i_start = (hs == stray_at);
        if (hs == stray_at) begin
          i_key     = ~key;
          i_decrypt = ~dec;
        end
        if (rdy) begin
          e = sb.pop_front();
          check("subkey", {16'd0, o_subkey}, {16'd0, e.sk});
          check("round", {59'd0, o_round}, {59'd0, e.rnd});
          check("last", {63'd0, o_last}, {63'd0, e.last});
          check("run_busy", {63'd0, o_busy}, 64'd1);
          hs++;
          hold = 0;
          if (start_at_last && hs == 16) i_start = 1'b1;
        end else begin
          hold   = 1;
          h_sk   = o_subkey;
          h_rnd  = o_round;
          h_last = o_last;
        end
        @(negedge i_clk);
        cyc++;
      end
    end
    i_start = 1'b0;
    i_subkey_ready = 1'b0;
    if (!aborted) begin
      check("handshakes", 64'(hs), 64'd16);
      check("done_valid", {63'd0, o_subkey_valid}, 64'd0);
      check("done_busy", {63'd0, o_busy}, 64'd0);
      check("done_last", {63'd0, o_last}, 64'd0);
      @(negedge i_clk);
      check("stay_idle", {63'd0, o_subkey_valid}, 64'd0);
    end
  endtask

  initial begin
    i_rst_n = 1'b0;
    i_start = 1'b0;
    i_decrypt = 1'b0;
    i_key = '0;
    i_subkey_ready = 1'b0;
    @(negedge i_clk);
    @(negedge i_clk);
    check("reset_valid", {63'd0, o_subkey_valid}, 64'd0);
    check("reset_busy", {63'd0, o_busy}, 64'd0);
    check("reset_last", {63'd0, o_last}, 64'd0);
    check("reset_round", {59'd0, o_round}, 64'd0);
    check("reset_subkey", {16'd0, o_subkey}, 64'd0);
    i_rst_n = 1'b1;

    // Encrypt then decrypt, ready held high.
    run_seq(KEY, 1'b0, 1'b0, -1, -1, 1'b0);
    run_seq(KEY, 1'b1, 1'b0, -1, -1, 1'b0);
    // Random backpressure in both directions.
    run_seq(KEY, 1'b0, 1'b1, -1, -1, 1'b0);
    run_seq(KEY, 1'b1, 1'b1, -1, -1, 1'b0);
    // Foreign start mid-run and start coinciding with the final handshake.
    run_seq(KEY, 1'b0, 1'b0, 5, -1, 1'b1);
    // Asynchronous reset after seven handshakes, then a clean restart.
    run_seq(KEY, 1'b0, 1'b0, -1, 7, 1'b0);
    run_seq(KEY, 1'b0, 1'b0, -1, -1, 1'b0);
    // Parity bits flipped must not change the schedule.
    run_seq(KEY ^ PAR_MSK, 1'b0, 1'b1, -1, -1, 1'b0);
    run_seq(KEY ^ PAR_MSK, 1'b1, 1'b0, -1, -1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/des_subkey_sequencer.md
# des_subkey_sequencer

Sequential DES key scheduler. It takes one 64-bit key and issues the 16 round subkeys one per handshake over a valid/ready stream. Order is K1→K16 for encryption, or K16→K1 for decryption; decryption uses right rotations of C/D. It feeds the single-round Feistel datapath of the iterative encrypt/decrypt core and replaces the all-16-in-parallel subkey generator where area matters.

## Interface
- No parameters; DES widths are fixed.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request; accepted only when busy=0
- decrypt  in  1  sampled with start; 0 = K1..K16, 1 = K16..K1
- key  in  [1:64]  DES key, bit 1 = MSB; parity bits 8,16,…,64 are ignored by PC-1
- busy  out  1  high from the accepted start until the last subkey is accepted
- subkey_valid  out  1  subkey is presented
- subkey_ready  in  1  consumer accepts the subkey when valid & ready
- subkey  out  [1:48]  PC-2 of the current C/D registers
- round  out  [4:0]  DES round number of the presented subkey, 1..16
- last  out  1  high with the 16th issued subkey

## Operation
- States: IDLE, RUN.
- **IDLE, start=1:**
  - Latch decrypt.
  - Load {C,D} = PC1(key).
  - Encrypt: apply a 1-bit left rotate at load, so C,D = C1,D1 and round=1.
  - Decrypt: load C0,D0 unrotated; this equals C16,D16 because total rotation is 28. Set round=16.
  - Clear count; go to RUN.
- **RUN:** subkey_valid=1. subkey = PC2(C,D) combinationally from the registers.
- **Handshake in RUN** (valid & ready):
  - count<15: count+1, advance C/D one step.
  - Encrypt step: left-rotate C and D each by SHIFT[round+1]; round+1.
  - Decrypt step: right-rotate C and D each by SHIFT[round]; round−1.
  - count==15: go to IDLE, deassert valid.
- SHIFT[1..16] = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
- Decrypt right-rotate sequence is therefore 1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
- Rotations act independently on the 28-bit C and D halves.
- last = RUN & (count==15).
- **Backpressure:** while ready=0, subkey, round and last hold stable and valid stays high.
- start in RUN is ignored. It does not restart, and decrypt/key are not re-sampled.
- start on the same cycle the final handshake completes is also ignored; the new start needs busy=0.

## Timing
- **Reset values:** state=IDLE, C=D=0, count=0, busy=0, subkey_valid=0, last=0, round=0, subkey=PC2(0)=0.
- **Latency:** start sampled at edge t → valid and first subkey visible after edge t (cycle t+1).
- **Throughput:** one subkey per cycle with ready held high; 16 cycles from first valid to the final handshake. busy falls after the edge of the 16th handshake.
- Outputs are registered-state-driven with no combinational path from subkey_ready to subkey, round or last. valid depends only on state.
- **Async reset mid-sequence:** returns to IDLE immediately. Outputs go to reset values with no further handshakes, and the partial sequence is discarded.

## Structure
- **Package des_key_pkg:**
  - PC1 table (56 entries)
  - PC2 table (48 entries)
  - SHIFT table (16 entries)
  - typedefs for 28-bit half and 48-bit subkey
- **Sub-module des_pc2:** purely combinational 56→48 permutation. It is shared with the parallel subkey generator.
- PC-1 and the rotators stay inline.
- Counter is 4-bit. round is derived from count and the latched decrypt flag, or kept as its own register.

## Test plan
- **Key 0x133457799BBCDFF1, decrypt=0, ready=1:**
  - first subkey 0x1B02EFFC7072 round=1
  - second 0x79AED9DBC9E5 round=2
  - sixteenth 0xCB3D8B0E17F5 round=16 with last=1
  - valid drops the next cycle
- **Same key, decrypt=1:** first 0xCB3D8B0E17F5 round=16, last item 0x1B02EFFC7072 round=1 with last=1. All 16 equal the encrypt sequence reversed.
- **Backpressure:** random ready, about 50% duty. Subkey, round and last stay stable while ready=0, and exactly 16 handshakes occur.
- **start pulsed during RUN with a different key:** ignored; the sequence completes unchanged and busy behaves normally.
- **rst_n asserted at handshake 7:** valid=0, busy=0, subkey=0 asynchronously. A fresh start then yields 0x1B02EFFC7072 first.
- **Parity insensitivity:** flipping key bits 8/16/…/64 produces identical subkeys.
